// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared types and constants for the multi-channel DDS scheduler.
//   sched_state_t : scheduler FSM states (IDLE, ISSUE, DRAIN)
//   CFG_*         : register-select codes carried on cfg_sel
// -----------------------------------------------------------------------------
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam logic [1:0] CFG_FTW    = 2'd0;
    localparam logic [1:0] CFG_OFFSET = 2'd1;
    localparam logic [1:0] CFG_ENABLE = 2'd2;

endpackage

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
// One DDS channel: shadow and active copies of FTW / phase offset / enable,
// the phase accumulator and the ROM address extraction.
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   wr_en       : configuration write addressed to this channel
//   cfg_sel     : register select (CFG_FTW / CFG_OFFSET / CFG_ENABLE)
//   cfg_data    : write data
//   commit      : frame start; copy shadow registers into the active set
//   step        : this channel's slot is being issued at the coming edge
//   en_eff      : enable value that applies to the slot issued at this edge
//   addr        : ROM address for the slot issued at this edge
//
// Build option: DDS_SCHED_ROUND_EN selects round-to-nearest address
// extraction instead of truncation.
// -----------------------------------------------------------------------------
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH    = 32,
    parameter int ROM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [1:0]                cfg_sel,
    input  logic [PHASE_WIDTH-1:0]    cfg_data,
    input  logic                      commit,
    input  logic                      step,
    output logic                      en_eff,
    output logic [ROM_ADDR_WIDTH-1:0] addr
);

`ifdef DDS_SCHED_ROUND_EN
    // Half an address LSB, so the extracted top bits round to nearest.
    localparam logic [PHASE_WIDTH-1:0] ROUND_BIAS =
        PHASE_WIDTH'(1) << (PHASE_WIDTH - ROM_ADDR_WIDTH - 1);
`else
    localparam logic [PHASE_WIDTH-1:0] ROUND_BIAS = '0;
`endif

    logic [PHASE_WIDTH-1:0] ftw_sh_q, ftw_sh_d;
    logic [PHASE_WIDTH-1:0] off_sh_q, off_sh_d;
    logic                   en_sh_q,  en_sh_d;
    logic [PHASE_WIDTH-1:0] ftw_q,    ftw_d;
    logic [PHASE_WIDTH-1:0] off_q,    off_d;
    logic                   en_q,     en_d;
    logic [PHASE_WIDTH-1:0] acc_q,    acc_d;

    logic [PHASE_WIDTH-1:0] ftw_eff;
    logic [PHASE_WIDTH-1:0] off_eff;
    logic [PHASE_WIDTH-1:0] phase_sum;

    always_comb begin
        ftw_sh_d = ftw_sh_q;
        off_sh_d = off_sh_q;
        en_sh_d  = en_sh_q;
        if (wr_en) begin
            case (cfg_sel)
                CFG_FTW:    ftw_sh_d = cfg_data;
                CFG_OFFSET: off_sh_d = cfg_data;
                CFG_ENABLE: en_sh_d  = cfg_data[0];
                default:    ;
            endcase
        end

        // Slot 0 is issued at the same edge that commits the frame, so it must
        // see the shadow values directly. The *_q shadow is used, so a write in
        // the commit cycle only lands in the shadow and waits for next frame.
        ftw_eff = commit ? ftw_sh_q : ftw_q;
        off_eff = commit ? off_sh_q : off_q;
        en_eff  = commit ? en_sh_q  : en_q;

        ftw_d = ftw_eff;
        off_d = off_eff;
        en_d  = en_eff;

        acc_d = acc_q;
        if (step) begin
            acc_d = en_eff ? (acc_q + ftw_eff) : '0;
        end

        phase_sum = acc_q + off_eff + ROUND_BIAS;
        addr      = phase_sum[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ftw_sh_q <= '0;
            off_sh_q <= '0;
            en_sh_q  <= 1'b0;
            ftw_q    <= '0;
            off_q    <= '0;
            en_q     <= 1'b0;
            acc_q    <= '0;
        end else begin
            ftw_sh_q <= ftw_sh_d;
            off_sh_q <= off_sh_d;
            en_sh_q  <= en_sh_d;
            ftw_q    <= ftw_d;
            off_q    <= off_d;
            en_q     <= en_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/dds_channel_scheduler.sv
// -----------------------------------------------------------------------------
// dds_channel_scheduler
// Shares one registered cosine ROM (1-cycle latency) between NUM_CH DDS
// channels. Each sample_tick walks slots 0..NUM_CH-1, one per cycle, driving
// rom_ce / rom_addr, and tags returned samples with their channel number.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   sample_tick       : frame start pulse; dropped (and overrun set) if busy
//   cfg_wr/ch/sel/data: shadow register write port, accepted in any state
//   rom_ce, rom_addr  : shared ROM request; rom_addr holds when rom_ce=0
//   rom_data          : ROM output, valid the cycle after rom_ce
//   out_valid/ch/data : tagged sample stream
//   busy              : frame in progress (ISSUE or DRAIN)
//   overrun           : sticky, tick seen while not IDLE
//   dbg_state         : current FSM state
//
// Handshake: no back-pressure. out_valid is a one-cycle qualifier; out_ch and
// out_data are meaningful only while out_valid=1 (out_data reads 0 otherwise).
//
// Timing (tick high in cycle T): slot k drives rom_ce in cycle T+1+k, its
// sample appears with out_valid in T+2+k, busy covers T+1..T+NUM_CH+1.
//
// Build option: DDS_SCHED_ROUND_EN (round-to-nearest address extraction).
// -----------------------------------------------------------------------------
module dds_channel_scheduler
    import dds_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PHASE_WIDTH    = 32,
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int ROM_WIDTH      = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_tick,
    input  logic                      cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [PHASE_WIDTH-1:0]    cfg_data,
    output logic                      rom_ce,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]      rom_data,
    output logic                      out_valid,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic [ROM_WIDTH-1:0]      out_data,
    output logic                      busy,
    output logic                      overrun,
    output sched_state_t              dbg_state
);

    localparam int CHW = $clog2(NUM_CH);
    localparam logic [CHW-1:0] LAST_SLOT = CHW'(NUM_CH - 1);

    sched_state_t              state_q,     state_d;
    logic [CHW-1:0]            slot_q,      slot_d;
    logic                      rom_ce_q,    rom_ce_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q,  rom_addr_d;
    logic                      out_valid_q, out_valid_d;
    logic [CHW-1:0]            out_ch_q,    out_ch_d;
    logic                      busy_q,      busy_d;
    logic                      overrun_q,   overrun_d;

    logic                      commit;
    logic                      issue;
    logic [CHW-1:0]            issue_slot;
    logic [NUM_CH-1:0]         ch_wr;
    logic [NUM_CH-1:0]         ch_step;
    logic [NUM_CH-1:0]         ch_en;
    logic [ROM_ADDR_WIDTH-1:0] ch_addr [NUM_CH];

    // The ROM request is registered, so the slot to be issued is decided one
    // edge early: at the tick edge for slot 0, then at each ISSUE edge for the
    // following slot. The channel accumulator steps at that same edge.
    assign commit     = (state_q == IDLE) && sample_tick;
    assign issue      = commit || ((state_q == ISSUE) && (slot_q != LAST_SLOT));
    assign issue_slot = (state_q == IDLE) ? '0 : (slot_q + CHW'(1));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_wr[gi]   = cfg_wr && (cfg_ch == CHW'(gi));
        assign ch_step[gi] = issue && (issue_slot == CHW'(gi));

        dds_phase_acc #(
            .PHASE_WIDTH    (PHASE_WIDTH),
            .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (ch_wr[gi]),
            .cfg_sel  (cfg_sel),
            .cfg_data (cfg_data),
            .commit   (commit),
            .step     (ch_step[gi]),
            .en_eff   (ch_en[gi]),
            .addr     (ch_addr[gi])
        );
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        overrun_d = overrun_q | (sample_tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    slot_d  = '0;
                end
            end
            ISSUE: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = DRAIN;
                end else begin
                    slot_d = slot_q + CHW'(1);
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rom_ce_d   = issue && ch_en[issue_slot];
        rom_addr_d = rom_ce_d ? ch_addr[issue_slot] : rom_addr_q;

        // slot_q names the slot whose request is on the ROM this cycle.
        out_valid_d = rom_ce_q;
        out_ch_d    = rom_ce_q ? slot_q : out_ch_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            rom_ce_q    <= 1'b0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            rom_ce_q    <= rom_ce_d;
            rom_addr_q  <= rom_addr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom_ce    = rom_ce_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    // The ROM's own output register is the sample stage; it is only qualified
    // here so out_data reads 0 outside valid cycles and during reset.
    assign out_data  = out_valid_q ? rom_data : '0;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
module tb_dds_channel_scheduler;
    import dds_pkg::*;

    localparam int NUM_CH = 4;
    localparam int PW     = 32;
    localparam int AW     = 12;
    localparam int RW     = 18;

`ifdef DDS_SCHED_ROUND_EN
    localparam logic [11:0] EXP_RND_ADDR = 12'd1;
`else
    localparam logic [11:0] EXP_RND_ADDR = 12'd0;
`endif

    typedef struct packed {
        logic [3:0]        en;
        logic [3:0][11:0]  addr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           sample_tick = 1'b0;
    logic           cfg_wr      = 1'b0;
    logic [1:0]     cfg_ch      = '0;
    logic [1:0]     cfg_sel     = '0;
    logic [PW-1:0]  cfg_data    = '0;
    logic           rom_ce;
    logic [AW-1:0]  rom_addr;
    logic [RW-1:0]  rom_data;
    logic           out_valid;
    logic [1:0]     out_ch;
    logic [RW-1:0]  out_data;
    logic           busy;
    logic           overrun;
    sched_state_t   dbg_state;

    dds_channel_scheduler #(
        .NUM_CH(NUM_CH), .PHASE_WIDTH(PW), .ROM_ADDR_WIDTH(AW), .ROM_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // Registered ROM stand-in: each address maps to a distinct sample value.
    function automatic logic [RW-1:0] rom_f(input logic [AW-1:0] a);
        return {a, 6'b101001};
    endfunction

    logic [RW-1:0] rom_q;
    always_ff @(posedge clk) begin
        if (rom_ce) rom_q <= rom_f(rom_addr);
    end
    assign rom_data = rom_q;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [11:0] last_addr = '0;
    logic        exp_ovr   = 1'b0;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] data);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
        @(posedge clk);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic run_frame(input logic [3:0] en, input logic [3:0][11:0] ea,
                             input int drop_at, input logic wr, input logic [1:0] wch,
                             input logic [1:0] wsel, input logic [31:0] wdata);
        logic [19:0] e;
        sample_tick = 1'b1;
        if (wr) begin
            cfg_wr = 1'b1; cfg_ch = wch; cfg_sel = wsel; cfg_data = wdata;
        end
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        cfg_wr      = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("busy_c%0d", c), 64'(busy), 64'(c <= 5));
            if (c <= 4) begin
                chk($sformatf("rom_ce_s%0d", c - 1), 64'(rom_ce), 64'(en[c-1]));
                if (en[c-1]) begin
                    chk($sformatf("rom_addr_s%0d", c - 1), 64'(rom_addr), 64'(ea[c-1]));
                    last_addr = ea[c-1];
                    exp_q.push_back({2'(c - 1), rom_f(ea[c-1])});
                end else begin
                    chk($sformatf("rom_addr_hold_s%0d", c - 1), 64'(rom_addr), 64'(last_addr));
                end
            end else begin
                chk("rom_ce_idle", 64'(rom_ce), 64'd0);
            end
            if (c >= 2 && c <= 5) begin
                chk($sformatf("out_valid_s%0d", c - 2), 64'(out_valid), 64'(en[c-2]));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_sample", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_ch", 64'(out_ch), 64'(e[19:18]));
                        chk("out_data", 64'(out_data), 64'(e[17:0]));
                    end
                end
            end else begin
                chk("out_valid_idle", 64'(out_valid), 64'd0);
            end
            sample_tick = (c == drop_at);
            if (c == drop_at) exp_ovr = 1'b1;
            @(negedge clk);
        end
        sample_tick = 1'b0;
        chk("overrun", 64'(overrun), 64'(exp_ovr));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic frame(input logic [3:0] en, input logic [3:0][11:0] ea);
        run_frame(en, ea, 0, 1'b0, 2'd0, 2'd0, 32'd0);
    endtask

    task automatic run_table(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            frame(tbl[i].en, tbl[i].addr);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0][11:0] a;

        for (int n = 0; n < 4; n++) begin
            tbl[n].en        = 4'b0001;
            tbl[n].addr      = '0;
            tbl[n].addr[0]   = 12'(n);
            tbl[4+n].en      = 4'b1111;
            tbl[4+n].addr[0] = 12'(n);
            tbl[4+n].addr[1] = 12'(2 * n);
            tbl[4+n].addr[2] = 12'(4 * n);
            tbl[4+n].addr[3] = 12'(8 * n);
            tbl[8+n].en      = 4'b0001;
            tbl[8+n].addr    = '0;
            tbl[8+n].addr[0] = 12'(4096 - n);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle", 64'({rom_ce, rom_addr, out_valid, out_ch, out_data, busy, overrun, dbg_state}), 64'd0);
            @(negedge clk);
        end

        // 2: single channel ramp
        cfg_write(2'd0, CFG_FTW, 32'h0010_0000);
        cfg_write(2'd0, CFG_ENABLE, 32'd1);
        for (int n = 0; n < 4; n++) begin
            frame(tbl[n].en, tbl[n].addr);
            @(negedge clk);
        end

        // disabled frame clears ch0 phase; rom_addr holds 3
        cfg_write(2'd0, CFG_ENABLE, 32'd0);
        frame(4'b0000, '0);

        // 3: all channels
        cfg_write(2'd1, CFG_FTW, 32'h0020_0000);
        cfg_write(2'd2, CFG_FTW, 32'h0040_0000);
        cfg_write(2'd3, CFG_FTW, 32'h0080_0000);
        for (int ch = 0; ch < 4; ch++) cfg_write(2'(ch), CFG_ENABLE, 32'd1);
        run_table(4, 4);

        // 4: offset on ch1, same-cycle write at tick
        for (int ch = 0; ch < 4; ch++) cfg_write(2'(ch), CFG_ENABLE, 32'd0);
        frame(4'b0000, '0);
        cfg_write(2'd1, CFG_FTW, 32'd0);
        cfg_write(2'd1, CFG_OFFSET, 32'h4000_0000);
        cfg_write(2'd1, CFG_ENABLE, 32'd1);
        a = '0; a[1] = 12'd1024;
        frame(4'b0010, a);
        run_frame(4'b0010, a, 0, 1'b1, 2'd1, CFG_OFFSET, 32'd0);
        a[1] = 12'd0;
        frame(4'b0010, a);

        // 5: tick 3 cycles into a frame is dropped
        run_frame(4'b0010, a, 3, 1'b0, 2'd0, 2'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("drop_no_extra", 64'({out_valid, busy, overrun}), 64'b001);
            @(negedge clk);
        end

        // 6: wrap with negative FTW
        cfg_write(2'd1, CFG_ENABLE, 32'd0);
        cfg_write(2'd0, CFG_FTW, 32'hFFF0_0000);
        cfg_write(2'd0, CFG_ENABLE, 32'd1);
        run_table(8, 4);

        // reset mid-ISSUE
        sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        chk("mid_rom_ce", 64'(rom_ce), 64'd1);
        chk("mid_rom_addr", 64'(rom_addr), 64'd4092);
        @(negedge clk);
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        chk("mid_out_data", 64'(out_data), 64'(rom_f(12'd4092)));
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({rom_ce, rom_addr, out_valid, out_ch, out_data, busy, overrun, dbg_state}), 64'd0);
        exp_q.delete();
        exp_ovr   = 1'b0;
        last_addr = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_idle", 64'({out_valid, busy, rom_ce}), 64'd0);
            @(negedge clk);
        end
        cfg_write(2'd0, CFG_OFFSET, 32'h0008_0000);
        cfg_write(2'd0, CFG_ENABLE, 32'd1);
        a = '0; a[0] = EXP_RND_ADDR;
        frame(4'b0001, a);
        frame(4'b0001, a);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
